// File: rtl/e_mdu.sv
// rtl/e_mdu.sv - multiply/divide unit with HI/LO registers and multi-cycle busy timing
module e_mdu (
    input  logic        clk,
    input  logic        reset,
    input  logic        Start,
    input  logic [3:0]  MDUop,
    input  logic [31:0] NUM1,
    input  logic [31:0] NUM2,
    output logic        Busy,
    output logic [31:0] HI,
    output logic [31:0] LO,
    output logic [31:0] MDUout
);
    localparam logic [3:0] OP_MULT  = 4'd1;
    localparam logic [3:0] OP_MULTU = 4'd2;
    localparam logic [3:0] OP_DIV   = 4'd3;
    localparam logic [3:0] OP_DIVU  = 4'd4;
    localparam logic [3:0] OP_MFHI  = 4'd5;
    localparam logic [3:0] OP_MFLO  = 4'd6;
    localparam logic [3:0] OP_MTHI  = 4'd7;
    localparam logic [3:0] OP_MTLO  = 4'd8;

    typedef enum logic {S_IDLE, S_BUSY} state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [3:0]  r_cnt;
    logic [3:0]  w_cnt_nxt;
    logic [3:0]  r_op;
    logic [31:0] r_a;
    logic [31:0] r_b;
    logic [31:0] r_hi;
    logic [31:0] r_lo;
    logic        w_launch;
    logic        w_done;

    logic        w_is_mdop;
    logic        w_is_div;
    logic [63:0] w_prod_s;
    logic [63:0] w_prod_u;
    logic        w_sgn;
    logic        w_a_neg;
    logic        w_b_neg;
    logic [31:0] w_abs_a;
    logic [31:0] w_abs_b;
    logic [31:0] w_q;
    logic [31:0] w_r;
    logic [31:0] w_res_hi;
    logic [31:0] w_res_lo;

    assign w_is_mdop = (MDUop >= OP_MULT) && (MDUop <= OP_DIVU);
    assign w_is_div  = (r_op == OP_DIV) || (r_op == OP_DIVU);

    // Sign-extending to 64 bits makes the low 64 bits of an unsigned multiply equal the signed product.
    assign w_prod_s = {{32{r_a[31]}}, r_a} * {{32{r_b[31]}}, r_b};
    assign w_prod_u = {32'd0, r_a} * {32'd0, r_b};

    // Signed divide on magnitudes; 0x80000000 / -1 falls out as 0x80000000 rem 0 naturally.
    assign w_sgn   = (r_op == OP_DIV);
    assign w_a_neg = w_sgn & r_a[31];
    assign w_b_neg = w_sgn & r_b[31];
    assign w_abs_a = w_a_neg ? (~r_a + 32'd1) : r_a;
    assign w_abs_b = w_b_neg ? (~r_b + 32'd1) : r_b;
    assign w_q     = (w_abs_b == 32'd0) ? 32'd0 : (w_abs_a / w_abs_b);
    assign w_r     = (w_abs_b == 32'd0) ? 32'd0 : (w_abs_a % w_abs_b);

    always_comb begin
        w_res_hi = r_hi;
        w_res_lo = r_lo;
        case (r_op)
            OP_MULT: begin
                w_res_hi = w_prod_s[63:32];
                w_res_lo = w_prod_s[31:0];
            end
            OP_MULTU: begin
                w_res_hi = w_prod_u[63:32];
                w_res_lo = w_prod_u[31:0];
            end
            OP_DIV, OP_DIVU: begin
                w_res_lo = (w_a_neg ^ w_b_neg) ? (~w_q + 32'd1) : w_q;
                w_res_hi = w_a_neg ? (~w_r + 32'd1) : w_r;
            end
            default: begin
                w_res_hi = r_hi;
                w_res_lo = r_lo;
            end
        endcase
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_launch    = 1'b0;
        w_done      = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (Start && w_is_mdop) begin
                    w_launch    = 1'b1;
                    w_state_nxt = S_BUSY;
                    w_cnt_nxt   = (MDUop == OP_MULT || MDUop == OP_MULTU) ? 4'd5 : 4'd10;
                end
            end
            S_BUSY: begin
                w_cnt_nxt = r_cnt - 4'd1;
                if (r_cnt == 4'd1) begin
                    w_done      = 1'b1;
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_cnt   <= 4'd0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_op <= 4'd0;
            r_a  <= 32'd0;
            r_b  <= 32'd0;
            r_hi <= 32'd0;
            r_lo <= 32'd0;
        end else begin
            if (w_launch) begin
                r_op <= MDUop;
                r_a  <= NUM1;
                r_b  <= NUM2;
            end
            if (w_done) begin
                if (!(w_is_div && (r_b == 32'd0))) begin
                    r_hi <= w_res_hi;
                    r_lo <= w_res_lo;
                end
            end else if (r_state == S_IDLE) begin
                if (MDUop == OP_MTHI) r_hi <= NUM1;
                if (MDUop == OP_MTLO) r_lo <= NUM1;
            end
        end
    end

    assign Busy   = (r_state == S_BUSY);
    assign HI     = r_hi;
    assign LO     = r_lo;
    assign MDUout = (MDUop == OP_MFHI) ? r_hi :
                    (MDUop == OP_MFLO) ? r_lo : 32'd0;
endmodule
